// File: rtl/alu_seq_unit_if.sv
// Request/result handshake bundle for the multi-cycle MUL/DIV sequencer.
// The master side issues operations and consumes results; the slave is the unit.
interface alu_seq_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] remainder;
    logic        zr;
    logic        ng;
    logic        dz;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, remainder, zr, ng, dz
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, remainder, zr, ng, dz
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Multi-cycle 16x16 multiply (low half) and unsigned restoring divide, sequenced
// as 16 iterations through a single 16-bit zx/nx/zy/ny/f/no ALU.
module alu_seq_unit #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input logic          clk,
    input logic          reset,
    alu_seq_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e      state_q;
    logic        op_q;
    // Datapath registers are shared: MUL uses acc/mcand/mplier, DIV uses rem/divisor/quo.
    logic [15:0] acc_q;
    logic [15:0] opnd_q;
    logic [15:0] sh_q;
    logic [4:0]  cnt_q;
    logic [15:0] result_q;
    logic [15:0] remainder_q;
    logic        zr_q;
    logic        ng_q;
    logic        dz_q;
    logic        in_ready_q;
    logic        out_valid_q;

    logic [5:0]  alu_ctrl;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [15:0] alu_out;
    logic [16:0] div_t;
    logic        div_ge;

    logic [15:0] acc_d;
    logic [15:0] opnd_d;
    logic [15:0] sh_d;
    logic [15:0] res_d;
    logic [4:0]  cnt_d;
    logic        finish;

    always_comb begin
        div_t  = {acc_q, sh_q[15]};
        div_ge = (div_t >= {1'b0, opnd_q});
        if (op_q) begin
            alu_ctrl = 6'b010011;
            alu_x    = div_t[15:0];
            alu_y    = opnd_q;
        end else begin
            alu_ctrl = 6'b000010;
            alu_x    = acc_q;
            alu_y    = opnd_q;
        end
    end

    always_comb begin : alu16
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] f;
        x       = alu_ctrl[5] ? '0 : alu_x;
        x       = alu_ctrl[4] ? ~x : x;
        y       = alu_ctrl[3] ? '0 : alu_y;
        y       = alu_ctrl[2] ? ~y : y;
        f       = alu_ctrl[1] ? (x + y) : (x & y);
        alu_out = alu_ctrl[0] ? ~f : f;
    end

    always_comb begin
        if (op_q) begin
            // t - b < b whenever t >= b, so the 16-bit subtract result is exact.
            acc_d  = div_ge ? alu_out : div_t[15:0];
            sh_d   = {sh_q[14:0], div_ge};
            opnd_d = opnd_q;
            res_d  = sh_d;
        end else begin
            acc_d  = sh_q[0] ? alu_out : acc_q;
            sh_d   = {1'b0, sh_q[15:1]};
            opnd_d = {opnd_q[14:0], 1'b0};
            res_d  = acc_d;
        end
        cnt_d  = cnt_q + 5'd1;
        finish = (cnt_q == 5'd15) || (EARLY_EXIT && !op_q && (sh_d == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 1'b0;
            acc_q       <= '0;
            opnd_q      <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_q       <= bus.op;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.op && (bus.b == '0)) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= '1;
                            remainder_q <= bus.a;
                            zr_q        <= 1'b0;
                            ng_q        <= 1'b1;
                            dz_q        <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            acc_q   <= '0;
                            opnd_q  <= bus.op ? bus.b : bus.a;
                            sh_q    <= bus.op ? bus.a : bus.b;
                        end
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    opnd_q <= opnd_d;
                    sh_q   <= sh_d;
                    cnt_q  <= cnt_d;
                    if (finish) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= res_d;
                        remainder_q <= op_q ? acc_d : '0;
                        zr_q        <= (res_d == '0);
                        ng_q        <= res_d[15];
                        dz_q        <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.remainder = remainder_q;
    assign bus.zr        = zr_q;
    assign bus.ng        = ng_q;
    assign bus.dz        = dz_q;

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Multi-cycle arithmetic sequencer built around one instance of the team's 16-bit ALU (controls zx/nx/zy/ny/f/no; outputs out/zr/ng).
- Adds 16x16 multiply (low 16 bits) and unsigned divide/remainder to the CPU datapath. Each operation is sequenced as 16 ALU iterations.
- Sits beside the main ALU as a coprocessor.
- Uses a valid/ready request handshake and a valid/ready result handshake.

Parameters:
- EARLY_EXIT, default 0: 1 = MUL finishes as soon as the remaining multiplier bits are all zero; 0 = fixed 16 iterations.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  1  0 = MUL, 1 = DIV (unsigned).
- a  in  16  multiplicand or dividend.
- b  in  16  multiplier or divisor.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  16  MUL: product[15:0]; DIV: quotient.
- remainder  out  16  DIV: remainder; MUL: 0.
- zr  out  1  result == 0.
- ng  out  1  result[15].
- dz  out  1  divide-by-zero flag for the current result.

Behaviour:
- Reset: state = IDLE, in_ready = 1, out_valid = 0, result = 0, remainder = 0, dz = 0, iteration counter = 0.
  - Reset mid-RUN or in DONE discards the operation; no output is produced.
- States: IDLE, RUN, DONE.
- Accept edge E0 happens when in_valid & in_ready.
  - Capture op, a, b and clear the counter.
  - Next state is RUN, except DIV with b == 0, which goes straight to DONE (see below).
- MUL in RUN:
  - Registers: acc (16), mcand (16), mplier (16). Load values: acc = 0, mcand = a, mplier = b.
  - Each edge: if mplier[0] = 1, acc <= ALU out with x = acc, y = mcand, controls 000010 (x+y); otherwise acc is unchanged.
  - Same edge: mcand <<= 1, mplier >>= 1 (logical).
  - Overflow beyond bit 15 is discarded. The low 16 bits are the same for signed and unsigned operands.
- DIV in RUN (restoring):
  - Registers: rem (16), quo (16). Load values: rem = 0, quo = a.
  - Per edge: t = {rem, quo[15]} (17 bits), compared unsigned against {0, b}.
  - If t >= b: rem <= ALU out with x = t[15:0], y = b, controls 010011 (x-y); quo <= {quo[14:0], 1}.
    - The 16-bit ALU result is exact here because t - b < b.
  - Else: rem <= t[15:0]; quo <= {quo[14:0], 0}.
- Divide by zero: on E0, state goes to DONE with result = 0xFFFF, remainder = a, dz = 1. out_valid rises after E0.
- Iteration count and latency:
  - The counter increments on each RUN edge. After the 16th iteration (E16), latch the outputs and go to DONE.
  - Output latch: result = acc or quo; remainder = 0 (MUL) or rem (DIV); dz = 0.
  - out_valid is visible after E16.
- EARLY_EXIT = 1, MUL only: if the shifted mplier is 0 on an iteration edge, latch and go to DONE on that same edge.
  - b = 0 therefore completes after E1.
- zr and ng are registered from the latched result. They are valid whenever out_valid is high.
- DONE:
  - result, remainder, zr, ng and dz hold stable while out_valid & !out_ready.
  - On the out_valid & out_ready edge, state goes to IDLE. out_valid falls and in_ready rises the following cycle; there is no same-cycle re-accept.
  - Outputs keep their last values in IDLE.
- in_valid is ignored outside IDLE. a, b and op may change freely after E0.

Test Plan:
- MUL a = 7, b = 6, EARLY_EXIT = 0 -> out_valid after exactly 16 edges from accept; result = 0x002A, remainder = 0, zr = 0, ng = 0.
- MUL a = 0xFFFD (-3), b = 5 -> result = 0xFFF1, ng = 1. MUL a = 0x0100, b = 0x0100 -> result = 0x0000, zr = 1.
- DIV a = 100, b = 7 -> result = 14, remainder = 2. DIV a = 0xFFFF, b = 0x8001 -> result = 1, remainder = 0x7FFE. Both take 16 edges.
- DIV a = 5, b = 0 -> out_valid one edge after accept; result = 0xFFFF, remainder = 5, dz = 1. The next normal op shows dz = 0.
- Backpressure: hold out_ready = 0 for 10 cycles after done -> outputs stable, in_ready = 0, and a new in_valid is not accepted. Release -> one handshake, then in_ready = 1 next cycle.
- Reset asserted at iteration 8 of a DIV -> next cycle IDLE, out_valid = 0, result = 0. With EARLY_EXIT = 1, MUL 7x6 -> done after 3 edges with result 42.
